// File: rtl/spi_pkg.sv
// Shared SPI definitions for the controller and target engines.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS = 8;

  // Bit 1 = CPOL, bit 0 = CPHA, matching the mode_i encoding.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [1:0] {
    TGT_IDLE   = 2'd0,
    TGT_SELECT = 2'd1,
    TGT_SHIFT  = 2'd2
  } spi_tgt_state_e;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer with optional rise/fall detection on the synced level.
module spi_target_sync
  import spi_pkg::*;
#(
  parameter bit EDGE_EN   = 1'b1,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], async_i};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_q <= {2{RESET_VAL}};
    else            sync_q <= sync_d;
  end

  assign sync_o = sync_q[1];

  generate
    if (EDGE_EN) begin : g_edge
      logic last_q, last_d;

      always_comb last_d = sync_q[1];

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) last_q <= RESET_VAL;
        else            last_q <= last_d;
      end

      assign rise_o = sync_q[1] & ~last_q;
      assign fall_o = ~sync_q[1] & last_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_target_engine.sv
// Byte-oriented SPI target engine, all four CPOL/CPHA modes, 8-bit frames.
// Optional macro SPI_TARGET_LSB_FIRST_EN selects LSB-first framing.
module spi_target_engine
  import spi_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       enable_i,
  input  logic [1:0] mode_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       spi_clk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_csn_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       underrun_o
);

`ifdef SPI_TARGET_LSB_FIRST_EN
  function automatic logic [7:0] rx_shift(input logic [7:0] sr, input logic bit_in);
    return {bit_in, sr[7:1]};
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] sr);
    return {1'b0, sr[7:1]};
  endfunction
  function automatic logic tx_bit(input logic [7:0] sr);
    return sr[0];
  endfunction
`else
  function automatic logic [7:0] rx_shift(input logic [7:0] sr, input logic bit_in);
    return {sr[6:0], bit_in};
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] sr);
    return {sr[6:0], 1'b0};
  endfunction
  function automatic logic tx_bit(input logic [7:0] sr);
    return sr[7];
  endfunction
`endif

  logic sclk_sync, sclk_rise, sclk_fall;
  logic csn_sync, csn_rise, csn_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_target_sync #(.EDGE_EN(1'b1), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .async_i   (spi_clk_i),
    .sync_o    (sclk_sync),
    .rise_o    (sclk_rise),
    .fall_o    (sclk_fall)
  );

  // CSN idles high, so its flops reset high to avoid a false select.
  spi_target_sync #(.EDGE_EN(1'b1), .RESET_VAL(1'b1)) u_sync_csn (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .async_i   (spi_csn_i),
    .sync_o    (csn_sync),
    .rise_o    (csn_rise),
    .fall_o    (csn_fall)
  );

  spi_target_sync #(.EDGE_EN(1'b0), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .async_i   (spi_mosi_i),
    .sync_o    (mosi_sync),
    .rise_o    (mosi_rise),
    .fall_o    (mosi_fall)
  );

  assign unused_sync = ^{sclk_sync, csn_sync, mosi_rise, mosi_fall};

  spi_tgt_state_e state_q, state_d;
  spi_mode_t      mode_q, mode_d;
  logic [7:0]     tx_sr_q, tx_sr_d;
  logic [7:0]     rx_sr_q, rx_sr_d;
  logic [7:0]     hold_q, hold_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           hold_full_q, hold_full_d;
  logic           reload_q, reload_d;
  logic           first_q, first_d;
  logic           rx_valid_q, rx_valid_d;
  logic           done_q, done_d;
  logic           underrun_q, underrun_d;
  logic           miso_q, miso_d;
  logic           active_q, active_d;

  logic           lead_e, trail_e, sample_e, shift_e;
  logic           load_tx, abort;

  // Map SCLK edges onto sample/shift edges for the latched mode.
  always_comb begin
    lead_e   = mode_q.cpol ? sclk_fall : sclk_rise;
    trail_e  = mode_q.cpol ? sclk_rise : sclk_fall;
    sample_e = mode_q.cpha ? trail_e : lead_e;
    shift_e  = mode_q.cpha ? lead_e  : trail_e;
  end

  // Next-state for the FSM, shift registers, holding buffer and pulses.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    reload_d    = reload_q;
    first_d     = first_q;
    rx_valid_d  = 1'b0;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    load_tx     = 1'b0;
    abort       = 1'b0;

    if (!enable_i) begin
      abort = 1'b1;
    end else begin
      case (state_q)
        TGT_IDLE: begin
          if (csn_fall) begin
            state_d = TGT_SELECT;
            mode_d  = spi_mode_t'(mode_i);
          end
        end
        TGT_SELECT: begin
          if (csn_rise) begin
            abort  = 1'b1;
            done_d = 1'b1;
          end else begin
            load_tx = 1'b1;
            state_d = TGT_SHIFT;
          end
        end
        TGT_SHIFT: begin
          if (csn_rise) begin
            abort  = 1'b1;
            done_d = 1'b1;
          end else if (sample_e) begin
            rx_sr_d   = rx_shift(rx_sr_q, mosi_sync);
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(SPI_FRAME_BITS - 1)) begin
              rx_data_d  = rx_sr_d;
              rx_valid_d = 1'b1;
              reload_d   = 1'b1;
            end
          end else if (shift_e) begin
            // A pending byte boundary turns this shift into a reload; with
            // CPHA=1 the very first leading edge leaves bit 7 in place.
            first_d = 1'b0;
            if (reload_q) begin
              load_tx  = 1'b1;
              reload_d = 1'b0;
            end else if (!(first_q && mode_q.cpha)) begin
              tx_sr_d = tx_shift(tx_sr_q);
            end
          end
        end
        default: abort = 1'b1;
      endcase
    end

    if (abort) begin
      state_d   = TGT_IDLE;
      bit_cnt_d = '0;
      rx_sr_d   = '0;
      reload_d  = 1'b0;
      first_d   = 1'b1;
    end

    if (load_tx) begin
      tx_sr_d     = hold_full_q ? hold_q : '0;
      underrun_d  = ~hold_full_q;
      hold_full_d = 1'b0;
    end

    // A capture in the same cycle as a load refills the buffer afterwards.
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    active_d = (state_d != TGT_IDLE);
    miso_d   = active_d & tx_bit(tx_sr_d);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= TGT_IDLE;
      mode_q      <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      reload_q    <= 1'b0;
      first_q     <= 1'b1;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      reload_q    <= reload_d;
      first_q     <= first_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      active_q    <= active_d;
    end
  end

  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = active_q;
  assign busy_o        = active_q;
  assign done_o        = done_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_spi_target_engine.sv
// Directed bench for spi_target_engine acting as the SPI controller.
module tb_spi_target_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sclk;
  logic       mosi;
  logic       csn;
  logic       miso;
  logic       miso_oe;
  logic       busy;
  logic       done;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  int n_rxv   = 0;
  int n_done  = 0;
  int n_under = 0;
  logic [7:0] rx_q[$];

  logic [14:0] outs;
  assign outs = {rx_data, rx_valid, tx_ready, miso, miso_oe, busy, done, underrun};

  always #5 clk = ~clk;

  spi_target_engine dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .enable_i      (enable),
    .mode_i        (mode),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .spi_clk_i     (sclk),
    .spi_mosi_i    (mosi),
    .spi_csn_i     (csn),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe),
    .busy_o        (busy),
    .done_o        (done),
    .underrun_o    (underrun)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv = n_rxv + 1;
      rx_q.push_back(rx_data);
    end
    if (done)     n_done  = n_done + 1;
    if (underrun) n_under = n_under + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic push_byte(input logic [7:0] b);
    int unsigned waited;
    waited = 0;
    while (!tx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: tx_ready=%b required 1 within 200 cycles", tx_ready);
    end else begin
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic begin_sel(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    repeat (4) @(negedge clk);
    csn = 1'b0;
  endtask

  task automatic end_sel();
    repeat (4) @(negedge clk);
    csn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Controller side: 4 clk periods per SCLK phase, MSB first.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        repeat (4) @(negedge clk);
        mi = {mi[6:0], miso};
        sclk = ~cpol;
        repeat (4) @(negedge clk);
        sclk = cpol;
      end else begin
        repeat (4) @(negedge clk);
        sclk = ~cpol;
        mosi = mo[i];
        repeat (4) @(negedge clk);
        mi = {mi[6:0], miso};
        sclk = cpol;
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    exp = {8'h00, 1'b0, 1'b1, 5'b00000};
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h required %h", outs, exp);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL reset_release: outputs=%h required %h", outs, exp);
    end
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    int rxv0, done0;
    push_byte(8'hA5);
    rxv0  = n_rxv;
    done0 = n_done;
    begin_sel(2'd0);
    spi_bits(8'h3C, 8, mi);
    checks++;
    if ({busy, miso_oe} !== 2'b11) begin
      errors++;
      $display("FAIL mode0_busy: busy,oe=%b required 11", {busy, miso_oe});
    end
    end_sel();
    checks++;
    if (mi !== 8'hA5) begin
      errors++;
      $display("FAIL mode0_miso: got %h required a5", mi);
    end
    checks++;
    if (rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL mode0_rx: got %h required 3c", rx_data);
    end
    checks++;
    if (n_rxv - rxv0 !== 1) begin
      errors++;
      $display("FAIL mode0_rxv_count: got %0d required 1", n_rxv - rxv0);
    end
    checks++;
    if (n_done - done0 !== 1) begin
      errors++;
      $display("FAIL mode0_done: got %0d required 1", n_done - done0);
    end
    checks++;
    if ({busy, miso_oe} !== 2'b00) begin
      errors++;
      $display("FAIL mode0_idle: busy,oe=%b required 00", {busy, miso_oe});
    end
  endtask

  task automatic test_modes();
    logic [7:0] mi;
    int rxv0;
    for (int m = 1; m < 4; m++) begin
      push_byte(8'h81);
      rxv0 = n_rxv;
      begin_sel(2'(m));
      spi_bits(8'h7E, 8, mi);
      end_sel();
      checks++;
      if (mi !== 8'h81) begin
        errors++;
        $display("FAIL mode%0d_miso: got %h required 81", m, mi);
      end
      checks++;
      if (rx_data !== 8'h7E) begin
        errors++;
        $display("FAIL mode%0d_rx: got %h required 7e", m, rx_data);
      end
      checks++;
      if (n_rxv - rxv0 !== 1) begin
        errors++;
        $display("FAIL mode%0d_rxv_count: got %0d required 1", m, n_rxv - rxv0);
      end
    end
  endtask

  // Mode 1: the reload happens on the next leading edge, so only the third
  // byte boundary finds the buffer empty.
  task automatic test_burst();
    logic [7:0] m0, m1, m2;
    int rxv0, und0, idx;
    push_byte(8'h11);
    rxv0 = n_rxv;
    und0 = n_under;
    idx  = rx_q.size();
    begin_sel(2'd1);
    fork
      spi_bits(8'hA1, 8, m0);
      push_byte(8'h22);
    join
    spi_bits(8'hB2, 8, m1);
    checks++;
    if (n_under - und0 !== 0) begin
      errors++;
      $display("FAIL burst_early_underrun: got %0d required 0", n_under - und0);
    end
    spi_bits(8'hC3, 8, m2);
    end_sel();
    checks++;
    if ({m0, m1, m2} !== 24'h112200) begin
      errors++;
      $display("FAIL burst_miso: got %h required 112200", {m0, m1, m2});
    end
    checks++;
    if (n_under - und0 !== 1) begin
      errors++;
      $display("FAIL burst_underrun: got %0d required 1", n_under - und0);
    end
    checks++;
    if (n_rxv - rxv0 !== 3) begin
      errors++;
      $display("FAIL burst_rxv_count: got %0d required 3", n_rxv - rxv0);
    end
    checks++;
    if (rx_q.size() < idx + 3 || {rx_q[idx], rx_q[idx+1], rx_q[idx+2]} !== 24'hA1B2C3) begin
      errors++;
      $display("FAIL burst_rx: size=%0d required 3 bytes a1b2c3", rx_q.size() - idx);
    end
  endtask

  task automatic test_partial();
    logic [7:0] mi;
    int rxv0, done0;
    push_byte(8'h5A);
    rxv0  = n_rxv;
    done0 = n_done;
    begin_sel(2'd0);
    spi_bits(8'hFF, 5, mi);
    end_sel();
    checks++;
    if (n_rxv - rxv0 !== 0) begin
      errors++;
      $display("FAIL partial_rxv: got %0d required 0", n_rxv - rxv0);
    end
    checks++;
    if (n_done - done0 !== 1) begin
      errors++;
      $display("FAIL partial_done: got %0d required 1", n_done - done0);
    end
    checks++;
    if (rx_data !== 8'hC3) begin
      errors++;
      $display("FAIL partial_rx_hold: got %h required c3", rx_data);
    end
    push_byte(8'h69);
    rxv0 = n_rxv;
    begin_sel(2'd0);
    spi_bits(8'h96, 8, mi);
    end_sel();
    checks++;
    if (mi !== 8'h69) begin
      errors++;
      $display("FAIL realign_miso: got %h required 69", mi);
    end
    checks++;
    if (rx_data !== 8'h96) begin
      errors++;
      $display("FAIL realign_rx: got %h required 96", rx_data);
    end
    checks++;
    if (n_rxv - rxv0 !== 1) begin
      errors++;
      $display("FAIL realign_rxv: got %0d required 1", n_rxv - rxv0);
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] mi;
    int rxv0, done0;
    push_byte(8'h33);
    rxv0  = n_rxv;
    done0 = n_done;
    begin_sel(2'd0);
    spi_bits(8'hAA, 3, mi);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, miso_oe} !== 2'b00) begin
      errors++;
      $display("FAIL enable_drop_oe: busy,oe=%b required 00", {busy, miso_oe});
    end
    repeat (4) @(negedge clk);
    csn = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (n_done - done0 !== 0) begin
      errors++;
      $display("FAIL enable_drop_done: got %0d required 0", n_done - done0);
    end
    checks++;
    if (n_rxv - rxv0 !== 0) begin
      errors++;
      $display("FAIL enable_drop_rxv: got %0d required 0", n_rxv - rxv0);
    end
    enable = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    logic [14:0] exp;
    exp = {8'h00, 1'b0, 1'b1, 5'b00000};
    push_byte(8'h44);
    begin_sel(2'd0);
    spi_bits(8'h55, 3, mi);
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL reset_mid: outputs=%h required %h", outs, exp);
    end
    @(negedge clk);
    csn  = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL reset_mid_release: outputs=%h required %h", outs, exp);
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    enable   = 1'b1;
    mode     = 2'd0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    sclk     = 1'b0;
    mosi     = 1'b0;
    csn      = 1'b1;
    test_reset();
    test_mode0();
    test_modes();
    test_burst();
    test_partial();
    test_enable_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
